// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: assembles WORD_W-wide words into a fracturable-LUT config and
// commits it with a one-cycle cen pulse followed by a one-cycle done pulse.
module lut_cfg_loader #(
   parameter int INPUTS   = 4,
   parameter int MEM_SIZE = 2**INPUTS,
   parameter int WORD_W   = 8
) (
   input  logic                  cclk,
   input  logic                  rst_n,
   input  logic [WORD_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  clear,
   output logic                  cen,
   output logic [2*MEM_SIZE:0]   config_in,
   output logic                  busy,
   output logic                  done
);
   localparam int CFG_W  = 2*MEM_SIZE+1;
   localparam int NWORDS = (CFG_W+WORD_W-1)/WORD_W;
   localparam int SW     = NWORDS*WORD_W;
   localparam int CW     = $clog2(NWORDS);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     count, count_nxt;
   logic [CFG_W-1:0]  shadow, shadow_nxt;
   logic [SW-1:0]     wide;
   logic              last;

   assign in_ready  = (state == IDLE) || (state == LOAD);
   assign busy      = (state != IDLE) || (count != '0);
   assign config_in = shadow;
   assign last      = count == CW'(NWORDS-1);

   always_ff @(posedge cclk or negedge rst_n)
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         shadow <= '0;
         cen    <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         shadow <= shadow_nxt;
         cen    <= state_nxt == COMMIT;
         done   <= state_nxt == DONE;
      end

   // Words land in a padded image so the top word's excess bits fall off cleanly.
   always_comb begin
      wide      = SW'(shadow);
      state_nxt = state;
      count_nxt = count;
      if (in_ready) begin
         if (clear) begin
            state_nxt = IDLE;
            count_nxt = '0;
         end else if (in_valid) begin
            wide[int'(count)*WORD_W +: WORD_W] = in_data;
            state_nxt = last ? COMMIT : LOAD;
            count_nxt = last ? '0 : count + 1'b1;
         end
      end else begin
         state_nxt = (state == COMMIT) ? DONE : IDLE;
         count_nxt = '0;
      end
      shadow_nxt = wide[CFG_W-1:0];
   end
endmodule
